pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 5, cycles a MUL occupies EX (legal range 2..16).
REQ-002 SHALL have parameter XLEN, default brisc_pkg XLEN (32), the width of the stall counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port dcache_miss, input, 1, a MEM-stage load/store is missing, held high until serviced.
REQ-006 SHALL have port dcache_ready, input, 1, a one-cycle pulse when the miss data is available.
REQ-007 SHALL have port mul_start, input, 1, a MUL is in EX for its first cycle.
REQ-008 SHALL have port redirect, input, 1, a taken branch or jump is resolved in EX.
REQ-009 SHALL have port load_use, input, 1, a load-use hazard exists between ID and EX.
REQ-010 SHALL have port icache_miss, input, 1, the IF fetch is not valid this cycle.
REQ-011 SHALL have port pc_en, output, 1, the PC register enable.
REQ-012 SHALL have port stage_en, output, 4, enables for the [0]=IF/ID, [1]=ID/EX, [2]=EX/MEM, [3]=MEM/WB registers.
REQ-013 SHALL have port stage_flush, output, 4, synchronous clears (bubble insert) for the same registers.
REQ-014 SHALL have port mul_busy, output, 1, high while a MUL holds EX.
REQ-015 SHALL have port stall_cycles, output, XLEN, count of cycles with pc_en=0.

Function
REQ-016 SHALL implement states RUN and DSTALL, plus a mul counter mcnt (4 bits); pc_en, stage_en, stage_flush and mul_busy are combinational from state, mcnt and the current inputs.
REQ-017 SHALL apply exactly one rule per cycle, chosen by the priority order in REQ-018 to REQ-023; each rule defaults to pc_en=1, stage_en=4'b1111 and stage_flush=0 except as stated.
REQ-018 Dcache stall (state==DSTALL and !dcache_ready, or state==RUN and dcache_miss) SHALL set pc_en=0 and stage_en[2:0]=0, and SHALL set stage_flush[3]=1.
REQ-019 MUL stall (mul_start accepted, or mcnt!=0) SHALL set pc_en=0 and stage_en[1:0]=0, and SHALL set stage_flush[2]=1.
REQ-020 Redirect SHALL set stage_flush[1:0]=2'b11.
REQ-021 Load-use SHALL set pc_en=0 and stage_en[0]=0, and SHALL set stage_flush[1]=1.
REQ-022 Icache miss SHALL set pc_en=0 and stage_flush[0]=1.
REQ-023 Otherwise (none of REQ-018 to REQ-022 applies), outputs SHALL keep all defaults.
REQ-024 Transition RUN->DSTALL SHALL occur on dcache_miss && !dcache_ready; DSTALL->RUN SHALL occur on dcache_ready; in the dcache_ready cycle the dcache stall is released and lower-priority rules apply.
REQ-025 mul_start SHALL be accepted only when mcnt==0 and no dcache stall is active; on acceptance mcnt loads MUL_LATENCY-2.
REQ-026 mul_start SHALL be ignored while mcnt!=0.
REQ-027 mcnt SHALL decrement when nonzero and no dcache stall is active, and SHALL freeze during a dcache stall.
REQ-028 A MUL SHALL hold EX for exactly MUL_LATENCY cycles absent dcache stalls: MUL_LATENCY-1 stalled cycles, with EX/MEM capturing on the last.
REQ-029 mul_busy SHALL equal (mul_start accepted) || mcnt!=0.
REQ-030 stall_cycles SHALL increment by 1 on every cycle with pc_en=0 and SHALL saturate at all-ones.
REQ-031 A flush bit SHALL dominate its enable bit: the register clears regardless of enable.

Reset
REQ-032 While reset_n=0 at a clock edge: state<=RUN, mcnt<=0, stall_cycles<=0.
REQ-033 While reset_n=0, outputs SHALL be pc_en=0, stage_en=4'b0000, stage_flush=4'b1111, mul_busy=0; all inputs are ignored.
REQ-034 Reset asserted mid-DSTALL or mid-MUL SHALL abandon the operation; after release the block is in RUN with mcnt=0.

Verification
REQ-035 Scenario: load_use=1 for one cycle -> pc_en=0, stage_en=4'b1110, stage_flush=4'b0010; the next cycle is all defaults; stall_cycles=1.
REQ-036 Scenario: mul_start=1 for one cycle, MUL_LATENCY=5 -> 4 cycles of mul_busy=1, pc_en=0, stage_en=4'b1100, stage_flush=4'b0100; 5th cycle all defaults; stall_cycles=4.
REQ-037 Scenario: dcache_miss held 3 cycles, then dcache_ready -> 3 cycles of stage_en=4'b1000, stage_flush=4'b1000; ready cycle defaults; state returns to RUN.
REQ-038 Scenario: dcache_miss arrives during a MUL at mcnt=2 for 2 cycles -> mcnt frozen at 2, dcache rule applies; after ready, 2 more MUL-stall cycles follow.
REQ-039 Scenario: redirect, load_use and icache_miss all high -> stage_flush=4'b0011, pc_en=1.
REQ-040 Scenario: reset_n=0 asserted during DSTALL -> outputs match REQ-033; after release with idle inputs, all defaults in the first cycle.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller arbitrating dcache misses, multi-cycle MUL and hazards
module pipeline_ctrl #(
  parameter int MUL_LATENCY = 5,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            dcache_miss,
  input  logic            dcache_ready,
  input  logic            mul_start,
  input  logic            redirect,
  input  logic            load_use,
  input  logic            icache_miss,
  output logic            pc_en,
  output logic [3:0]      stage_en,
  output logic [3:0]      stage_flush,
  output logic            mul_busy,
  output logic [XLEN-1:0] stall_cycles
);
  typedef enum logic {RUN, DSTALL} state_t;
  state_t state_q, state_d;
  logic [3:0] mcnt_q, mcnt_d;
  logic [XLEN-1:0] stall_q, stall_d;
  logic dstall, mul_acc, mstall;
  always_comb begin
    dstall = state_q == DSTALL ? !dcache_ready : dcache_miss;
    mul_acc = mul_start && mcnt_q == 4'd0 && !dstall;
    mstall = mul_acc || mcnt_q != 4'd0;
    {pc_en, stage_en, stage_flush} = !reset_n   ? 9'b0_0000_1111 :
                                     dstall     ? 9'b0_1000_1000 :
                                     mstall     ? 9'b0_1100_0100 :
                                     redirect   ? 9'b1_1111_0011 :
                                     load_use   ? 9'b0_1110_0010 :
                                     icache_miss ? 9'b0_1111_0001 :
                                                  9'b1_1111_0000;
    mul_busy = reset_n && mstall;
    state_d = state_q == RUN ? (dcache_miss && !dcache_ready ? DSTALL : RUN)
                             : (dcache_ready ? RUN : DSTALL);
    mcnt_d = dstall ? mcnt_q : mul_acc ? 4'(MUL_LATENCY - 2) : mcnt_q != 4'd0 ? mcnt_q - 4'd1 : 4'd0;
    stall_d = !pc_en && stall_q != '1 ? stall_q + XLEN'(1) : stall_q;
    stall_cycles = stall_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RUN;
      mcnt_q <= 4'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q <= mcnt_d;
      stall_q <= stall_d;
    end
  end
endmodule
